// File: rtl/i2c_reg_ctrl_if.sv
// Bus bundle between the i2c slave / LED refresh engine and the register controller.
// slave modport: the register controller. master modport: whoever drives i2c bytes and reads.
interface i2c_reg_ctrl_if;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_data;
    logic       i2c_valid;
    logic       i2c_start;
    logic       i2c_stop;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       update;
    logic       addr_err;
    logic       overrun;

    modport slave (
        input  i2c_addr,
        input  i2c_data,
        input  i2c_valid,
        input  i2c_start,
        input  i2c_stop,
        input  rd_req,
        input  rd_addr,
        output rd_data,
        output rd_valid,
        output update,
        output addr_err,
        output overrun
    );

    modport master (
        output i2c_addr,
        output i2c_data,
        output i2c_valid,
        output i2c_start,
        output i2c_stop,
        output rd_req,
        output rd_addr,
        input  rd_data,
        input  rd_valid,
        input  update,
        input  addr_err,
        input  overrun
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: turns i2c slave bytes into addressed writes of the LED register bank and
// shares the bank with the refresh engine's read port. A 1-deep pending buffer decouples byte
// capture from the bank; a small IDLE/WR/RD FSM serialises writes and reads.
// Build option: define I2C_REG_AUTOINC_EN to make successive bytes of a frame target
// consecutive addresses (burst writes); otherwise every byte hits the frame's start address.
module i2c_reg_ctrl #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    i2c_reg_ctrl_if.slave bus
);
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_valid_q;
    logic       r_first;
    logic [7:0] r_ptr;
    logic       r_pend;
    logic [7:0] r_pend_addr;
    logic [7:0] r_pend_data;

    logic       r_dirty;
    logic       r_stop_seen;
    logic       r_addr_err;
    logic       r_overrun;
    logic       r_update;
    logic       r_rd_valid;
    logic [7:0] r_rd_data;

    logic [7:0] r_regs [NUM_REGS];

    logic       w_rise;
    logic       w_first;
    logic [7:0] w_tgt;
    logic       w_wr_en;
    logic       w_rd_en;
    logic       w_wr_in_range;
    logic [7:0] w_rd_word;
    logic       w_service;
    logic       w_fire;

    // Byte-edge detect, target address selection and write/read qualifiers
    always_comb begin
        w_rise  = bus.i2c_valid & ~r_valid_q;
        // A START in the same cycle as a byte still makes that byte the frame's first
        w_first = r_first | bus.i2c_start;
`ifdef I2C_REG_AUTOINC_EN
        w_tgt   = w_first ? bus.i2c_addr : r_ptr + 8'd1;
`else
        w_tgt   = w_first ? bus.i2c_addr : r_ptr;
`endif
        w_wr_en       = (r_state == StWr);
        w_rd_en       = (r_state == StRd);
        w_wr_in_range = ({24'd0, r_pend_addr} < NUM_REGS);
        // STOP is serviced only once nothing of the frame is still in flight
        w_service     = r_stop_seen & ~r_pend & (r_state != StWr);
        // A START arriving first turns the STOP into a repeated start: no update
        w_fire        = w_service & r_dirty & ~bus.i2c_start;
    end

    // Read mux; addresses outside the bank read as zero
    always_comb begin
        w_rd_word = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr == 8'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // Byte capture into the pending buffer and frame pointer tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_q   <= 1'b0;
            r_first     <= 1'b1;
            r_ptr       <= 8'h00;
            r_pend      <= 1'b0;
            r_pend_addr <= 8'h00;
            r_pend_data <= 8'h00;
        end else begin
            r_valid_q <= bus.i2c_valid;
            if (bus.i2c_start) begin
                r_first <= 1'b1;
            end
            if (w_rise) begin
                // A byte landing while a WR drains the slot reloads it; the old one still commits
                r_pend      <= 1'b1;
                r_pend_addr <= w_tgt;
                r_pend_data <= bus.i2c_data;
                r_ptr       <= w_tgt;
                r_first     <= 1'b0;
            end else if (w_wr_en) begin
                r_pend <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: writes win over reads, a read waiting behind a write goes next
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_pend || w_rise) begin
                    w_state_nxt = StWr;
                end else if (bus.rd_req && !r_rd_valid) begin
                    // rd_req may still be high in the completion cycle; do not re-issue
                    w_state_nxt = StRd;
                end
            end
            StWr:    w_state_nxt = bus.rd_req ? StRd : StIdle;
            StRd:    w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else if (w_wr_en && w_wr_in_range) begin
            r_regs[r_pend_addr[AW-1:0]] <= r_pend_data;
        end
    end

    // Read port: data and completion strobe registered at the end of the RD cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    // Frame status: dirty/stop tracking, update pulse and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dirty     <= 1'b0;
            r_stop_seen <= 1'b0;
            r_addr_err  <= 1'b0;
            r_overrun   <= 1'b0;
            r_update    <= 1'b0;
        end else begin
            r_update <= w_fire;

            if (bus.i2c_start) begin
                r_stop_seen <= 1'b0;
            end else if (bus.i2c_stop) begin
                r_stop_seen <= 1'b1;
            end else if (w_service) begin
                r_stop_seen <= 1'b0;
            end

            // START opens a new frame, so it overrides anything the old frame's last write set
            if (bus.i2c_start) begin
                r_dirty <= 1'b0;
            end else if (w_fire) begin
                r_dirty <= 1'b0;
            end else if (w_wr_en && w_wr_in_range) begin
                r_dirty <= 1'b1;
            end

            if (bus.i2c_start) begin
                r_addr_err <= 1'b0;
            end else if (w_wr_en && !w_wr_in_range) begin
                r_addr_err <= 1'b1;
            end

            if (bus.i2c_start) begin
                r_overrun <= 1'b0;
            end else if (w_rise && r_pend) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Output drive
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.update   = r_update;
    assign bus.addr_err = r_addr_err;
    assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: directed scenarios plus randomized frames checked
// against a transaction-level register model. Honours I2C_REG_AUTOINC_EN like the design.
module tb_i2c_reg_ctrl;
    localparam int unsigned NREGS = 16;
    localparam logic [7:0]  RST   = 8'hA5;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    int   upd_cnt;

    logic [7:0] m_regs [NREGS];
    bit         exp_err;
    bit         exp_dirty;

    i2c_reg_ctrl_if bus ();

    i2c_reg_ctrl #(
        .NUM_REGS(NREGS),
        .RST_VAL (RST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses away from the active edge
    always @(negedge clk) begin
        if (bus.update === 1'b1) upd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NREGS; i++) m_regs[i] = RST;
    endtask

    function automatic logic [7:0] model_target(input logic [7:0] a, input int k);
`ifdef I2C_REG_AUTOINC_EN
        return a + 8'(k);
`else
        return a;
`endif
    endfunction

    task automatic model_apply(input logic [7:0] tgt, input logic [7:0] d);
        if (tgt < NREGS) begin
            m_regs[tgt] = d;
            exp_dirty   = 1'b1;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        return (a < NREGS) ? m_regs[a] : 8'h00;
    endfunction

    task automatic pulse_start(input logic [7:0] a);
        bus.i2c_addr  = a;
        bus.i2c_start = 1'b1;
        tick;
        bus.i2c_start = 1'b0;
        exp_err       = 1'b0;
        exp_dirty     = 1'b0;
    endtask

    task automatic pulse_stop;
        bus.i2c_stop = 1'b1;
        tick;
        bus.i2c_stop = 1'b0;
    endtask

    // One byte with a generous idle gap so it commits before anything else happens
    task automatic send_byte(input logic [7:0] d, input logic [7:0] tgt);
        bus.i2c_data  = d;
        bus.i2c_valid = 1'b1;
        tick;
        bus.i2c_valid = 1'b0;
        repeat (3) tick;
        model_apply(tgt, d);
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] data, output int lat,
                           output bit ok);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        lat  = 0;
        ok   = 1'b0;
        data = 8'hxx;
        while (lat < 10 && !ok) begin
            tick;
            lat++;
            if (bus.rd_valid === 1'b1) begin
                ok   = 1'b1;
                data = bus.rd_data;
            end
        end
        bus.rd_req = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        int         lat;
        bit         ok;
        reset = 1'b1;
        repeat (3) tick;
        n_cmp++;
        if ({bus.rd_data, bus.rd_valid, bus.update, bus.addr_err, bus.overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 000",
                     {bus.rd_data, bus.rd_valid, bus.update, bus.addr_err, bus.overrun});
        end
        reset = 1'b0;
        model_reset();
        tick;
        foreach (m_regs[i]) begin
            if (i == 0 || i == NREGS - 1) begin
                do_read(8'(i), d, lat, ok);
                n_cmp++;
                if (!ok || d !== RST || lat != 2) begin
                    n_fail++;
                    $display("FAIL reset_read[%0d]: got ok=%0d data=%h lat=%0d, required data=%h lat=2",
                             i, ok, d, lat, RST);
                end
            end
        end
        do_read(8'd200, d, lat, ok);
        n_cmp++;
        if (!ok || d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_read_oob: got ok=%0d data=%h, required 00", ok, d);
        end
    endtask

    task automatic test_burst;
        logic [7:0] d;
        logic [7:0] e3;
        logic [7:0] e4;
        int         lat;
        bit         ok;
        int         u0;
        u0 = upd_cnt;
        pulse_start(8'h03);
        send_byte(8'hAA, model_target(8'h03, 0));
        send_byte(8'h55, model_target(8'h03, 1));
        pulse_stop;
        repeat (5) tick;
        n_cmp++;
        if (upd_cnt - u0 != 1) begin
            n_fail++;
            $display("FAIL burst_update: got %0d pulses, required 1", upd_cnt - u0);
        end
`ifdef I2C_REG_AUTOINC_EN
        e3 = 8'hAA;
        e4 = 8'h55;
`else
        e3 = 8'h55;
        e4 = RST;
`endif
        do_read(8'h03, d, lat, ok);
        n_cmp++;
        if (!ok || d !== e3) begin
            n_fail++;
            $display("FAIL burst_reg3: got %h, required %h", d, e3);
        end
        do_read(8'h04, d, lat, ok);
        n_cmp++;
        if (!ok || d !== e4) begin
            n_fail++;
            $display("FAIL burst_reg4: got %h, required %h", d, e4);
        end
    endtask

    task automatic test_addr_err;
        logic [7:0] d;
        int         lat;
        bit         ok;
        int         u0;
        u0 = upd_cnt;
        pulse_start(8'h0F);
        for (int k = 0; k < 3; k++) send_byte(8'(8'h30 + k), model_target(8'h0F, k));
        pulse_stop;
        repeat (5) tick;
        n_cmp++;
        if (bus.addr_err !== exp_err) begin
            n_fail++;
            $display("FAIL addr_err_set: got %b, required %b", bus.addr_err, exp_err);
        end
        n_cmp++;
        if (upd_cnt - u0 != 1) begin
            n_fail++;
            $display("FAIL addr_err_update: got %0d pulses, required 1", upd_cnt - u0);
        end
        for (int a = 14; a < 17; a++) begin
            do_read(8'(a), d, lat, ok);
            n_cmp++;
            if (!ok || d !== model_read(8'(a))) begin
                n_fail++;
                $display("FAIL addr_err_read[%0d]: got %h, required %h", a, d, model_read(8'(a)));
            end
        end
        do_read(8'h00, d, lat, ok);
        n_cmp++;
        if (!ok || d !== model_read(8'h00)) begin
            n_fail++;
            $display("FAIL addr_err_nowrap: got %h, required %h", d, model_read(8'h00));
        end
        // Empty frame: clears the flag, no update
        u0 = upd_cnt;
        pulse_start(8'h00);
        tick;
        n_cmp++;
        if (bus.addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_err_clear: got %b, required 0", bus.addr_err);
        end
        pulse_stop;
        repeat (5) tick;
        n_cmp++;
        if (upd_cnt - u0 != 0) begin
            n_fail++;
            $display("FAIL empty_frame_update: got %0d pulses, required 0", upd_cnt - u0);
        end
    endtask

    task automatic test_collision;
        logic [7:0] d;
        int         lat;
        bit         ok;
        pulse_start(8'h03);
        bus.i2c_data  = 8'h3C;
        bus.i2c_valid = 1'b1;
        bus.rd_addr   = 8'h03;
        bus.rd_req    = 1'b1;
        lat = 0;
        ok  = 1'b0;
        d   = 8'hxx;
        while (lat < 10 && !ok) begin
            tick;
            lat++;
            bus.i2c_valid = 1'b0;
            if (bus.rd_valid === 1'b1) begin
                ok = 1'b1;
                d  = bus.rd_data;
            end
        end
        bus.rd_req = 1'b0;
        model_apply(8'h03, 8'h3C);
        n_cmp++;
        if (!ok || lat != 3) begin
            n_fail++;
            $display("FAIL collision_latency: got ok=%0d lat=%0d, required lat=3", ok, lat);
        end
        n_cmp++;
        if (d !== 8'h3C) begin
            n_fail++;
            $display("FAIL collision_data: got %h, required 3c", d);
        end
        pulse_stop;
        repeat (5) tick;
    endtask

    task automatic test_repeated_start;
        logic [7:0] d;
        int         lat;
        bit         ok;
        int         u0;
        u0 = upd_cnt;
        pulse_start(8'h06);
        send_byte(8'h61, model_target(8'h06, 0));
        pulse_stop;
        pulse_start(8'h07);
        send_byte(8'h71, model_target(8'h07, 0));
        pulse_stop;
        repeat (5) tick;
        n_cmp++;
        if (upd_cnt - u0 != 1) begin
            n_fail++;
            $display("FAIL repeated_start_update: got %0d pulses, required 1", upd_cnt - u0);
        end
        do_read(8'h06, d, lat, ok);
        n_cmp++;
        if (!ok || d !== model_read(8'h06)) begin
            n_fail++;
            $display("FAIL repeated_start_reg6: got %h, required %h", d, model_read(8'h06));
        end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        int         lat;
        bit         ok;
        int         u0;
        u0 = upd_cnt;
        pulse_start(8'h08);
        bus.rd_addr = 8'h00;
        bus.rd_req  = 1'b1;
        tick;                               // read accepted, FSM busy reading
        bus.i2c_data  = 8'hD1;
        bus.i2c_valid = 1'b1;
        tick;                               // first byte lands in the buffer
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== model_read(8'h00)) begin
            n_fail++;
            $display("FAIL overrun_read: got valid=%b data=%h, required valid=1 data=%h",
                     bus.rd_valid, bus.rd_data, model_read(8'h00));
        end
        bus.rd_req    = 1'b0;
        bus.i2c_valid = 1'b0;
        tick;                               // write of the first byte starts
        bus.i2c_data  = 8'hD2;
        bus.i2c_valid = 1'b1;
        tick;                               // second byte arrives while the first still pending
        bus.i2c_valid = 1'b0;
        model_apply(model_target(8'h08, 0), 8'hD1);
        model_apply(model_target(8'h08, 1), 8'hD2);
        n_cmp++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b, required 1", bus.overrun);
        end
        repeat (4) tick;
        pulse_stop;
        repeat (5) tick;
        n_cmp++;
        if (bus.overrun !== 1'b1 || upd_cnt - u0 != 1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got overrun=%b updates=%0d, required 1 and 1",
                     bus.overrun, upd_cnt - u0);
        end
        for (int a = 8; a < 10; a++) begin
            do_read(8'(a), d, lat, ok);
            n_cmp++;
            if (!ok || d !== model_read(8'(a))) begin
                n_fail++;
                $display("FAIL overrun_read[%0d]: got %h, required %h", a, d, model_read(8'(a)));
            end
        end
        pulse_start(8'h00);
        tick;
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b, required 0", bus.overrun);
        end
        pulse_stop;
        repeat (5) tick;
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [7:0] ra;
        logic [7:0] d;
        int         nb;
        int         lat;
        bit         ok;
        int         u0;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(250, 255));
            else                           a = 8'($urandom_range(0, 19));
            nb = $urandom_range(0, 4);
            u0 = upd_cnt;
            pulse_start(a);
            for (int k = 0; k < nb; k++) send_byte(8'($urandom), model_target(a, k));
            pulse_stop;
            repeat (5) tick;
            n_cmp++;
            if (upd_cnt - u0 != int'(exp_dirty)) begin
                n_fail++;
                $display("FAIL rand_update[%0d]: got %0d pulses, required %0d",
                         it, upd_cnt - u0, int'(exp_dirty));
            end
            n_cmp++;
            if (bus.addr_err !== exp_err || bus.overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got addr_err=%b overrun=%b, required %b and 0",
                         it, bus.addr_err, bus.overrun, exp_err);
            end
            for (int r = 0; r < 2; r++) begin
                ra = 8'($urandom_range(0, NREGS + 3));
                do_read(ra, d, lat, ok);
                n_cmp++;
                if (!ok || lat != 2 || d !== model_read(ra)) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d] addr %h: got ok=%0d lat=%0d data=%h, required lat=2 data=%h",
                             it, ra, ok, lat, d, model_read(ra));
                end
            end
        end
    endtask

    task automatic test_reset_mid_wr;
        logic [7:0] d;
        int         lat;
        bit         ok;
        pulse_start(8'h05);
        send_byte(8'hC3, model_target(8'h05, 0));
        do_read(8'h05, d, lat, ok);
        n_cmp++;
        if (!ok || d !== 8'hC3) begin
            n_fail++;
            $display("FAIL pre_reset_read: got %h, required c3", d);
        end
        pulse_start(8'h02);
        bus.i2c_data  = 8'h77;
        bus.i2c_valid = 1'b1;
        tick;                               // write to reg 2 now in progress
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.rd_data, bus.rd_valid, bus.update, bus.addr_err, bus.overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL midwr_reset_outputs: got %h, required 000",
                     {bus.rd_data, bus.rd_valid, bus.update, bus.addr_err, bus.overrun});
        end
        bus.i2c_valid = 1'b0;
        model_reset();
        repeat (2) tick;
        reset = 1'b0;
        tick;
        for (int a = 2; a < 6; a += 3) begin
            do_read(8'(a), d, lat, ok);
            n_cmp++;
            if (!ok || d !== RST) begin
                n_fail++;
                $display("FAIL midwr_reg[%0d]: got %h, required %h", a, d, RST);
            end
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        upd_cnt       = 0;
        exp_err       = 1'b0;
        exp_dirty     = 1'b0;
        reset         = 1'b1;
        bus.i2c_addr  = 8'h00;
        bus.i2c_data  = 8'h00;
        bus.i2c_valid = 1'b0;
        bus.i2c_start = 1'b0;
        bus.i2c_stop  = 1'b0;
        bus.rd_req    = 1'b0;
        bus.rd_addr   = 8'h00;
        test_reset();
        test_burst();
        test_addr_err();
        test_collision();
        test_repeated_start();
        test_overrun();
        test_random();
        test_reset_mid_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
